// File: rtl/led_frame_tx.sv
// Serializes a latched 16-zone RGB snapshot onto a WS2812-style single-wire chain
// (GRB, MSB first, 4-bit means replicated to 8 bits), then holds the line low for the latch gap.
module led_frame_tx #(
    parameter int T0H    = 20,
    parameter int T1H    = 40,
    parameter int TBIT   = 63,
    parameter int TRESET = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [3:0] MeanR [15:0],
    input  logic [3:0] MeanG [15:0],
    input  logic [3:0] MeanB [15:0],
    output logic       led_dout,
    output logic       busy,
    output logic       done
);
    localparam int PW = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int GW = (TRESET > 0) ? $clog2(TRESET + 1) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(TBIT - 1);
    localparam logic [PW-1:0] TH0     = PW'(T0H);
    localparam logic [PW-1:0] TH1     = PW'(T1H);
    localparam logic [GW-1:0] GAP_END = GW'(TRESET);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_phase;
    logic [4:0]       r_bit;
    logic [3:0]       r_zone;
    logic [GW-1:0]    r_gap;
    logic [15:0][3:0] r_mr, r_mg, r_mb;

    logic [23:0]      w_word;
    logic             w_bit;
    logic [PW-1:0]    w_thr;
    logic             w_last_phase, w_last_bit, w_last_zone, w_gap_end;
    logic             w_dout_nxt, w_busy_nxt, w_done_nxt;

    // Counters describe the bit slot that the output register captures on the next edge,
    // so the serial line lags them by exactly one cycle.
    assign w_word       = {r_mg[r_zone], r_mg[r_zone], r_mr[r_zone], r_mr[r_zone],
                           r_mb[r_zone], r_mb[r_zone]};
    assign w_bit        = w_word[5'd23 - r_bit];
    assign w_thr        = w_bit ? TH1 : TH0;
    assign w_last_phase = (r_phase == PH_LAST);
    assign w_last_bit   = (r_bit == 5'd23);
    assign w_last_zone  = (r_zone == 4'd15);
    assign w_gap_end    = (r_gap == GAP_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            led_dout <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            led_dout <= w_dout_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_nxt = SEND;
            SEND:    if (w_last_phase && w_last_bit && w_last_zone) w_state_nxt = GAP;
            GAP:     if (w_gap_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_dout_nxt = (r_state == SEND) && (r_phase < w_thr);
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (r_state == GAP) && w_gap_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_bit   <= '0;
            r_zone  <= '0;
            r_gap   <= '0;
            r_mr    <= '0;
            r_mg    <= '0;
            r_mb    <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_phase <= '0;
                    r_bit   <= '0;
                    r_zone  <= '0;
                    r_gap   <= '0;
                    for (int z = 0; z < 16; z++) begin
                        r_mr[z] <= MeanR[z];
                        r_mg[z] <= MeanG[z];
                        r_mb[z] <= MeanB[z];
                    end
                end
                SEND: begin
                    if (w_last_phase) begin
                        r_phase <= '0;
                        if (w_last_bit) begin
                            r_bit  <= '0;
                            r_zone <= r_zone + 4'd1;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                GAP:     r_gap <= w_gap_end ? '0 : r_gap + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
